adc_capture_sequencer: RTL

//  Sequences sinc3 ADC output words from up to NCH channels into the four 32x512 SRAM banks.
//  The banks are treated as one linear buffer of NBANK*2^AW words.
//  Per-channel one-word holding registers feed a round-robin arbiter, which drives the single

---
 rtl/adc_capture_sequencer_if.sv | 26 ++
 rtl/adc_capture_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer_if.sv
// SRAM write-port bundle driven by the capture sequencer.
// master drives the shared csb0/web0, addr0, din0 and wmask0 lines.
interface adc_capture_sequencer_if #(
   parameter int DW    = 32,
   parameter int AW    = 9,
   parameter int NBANK = 4
);
   logic [NBANK-1:0] mem_wenb_o;
   logic [AW-1:0]    mem_waddr_o;
   logic [DW-1:0]    mem_data_o;
   logic [3:0]       wmask_o;

   modport master (
      output mem_wenb_o,
      output mem_waddr_o,
      output mem_data_o,
      output wmask_o
   );

   modport slave (
      input mem_wenb_o,
      input mem_waddr_o,
      input mem_data_o,
      input wmask_o
   );
endinterface

// File: rtl/adc_capture_sequencer.sv
// Captures ADC words from NCH channels into NBANK SRAM banks
// through per-channel holding registers and a round-robin arbiter.
module adc_capture_sequencer #(
   parameter int NCH   = 3,
   parameter int DW    = 32,
   parameter int AW    = 9,
   parameter int NBANK = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [NCH-1:0]        ch_en_i,
   input  logic [11:0]           length_i,
   input  logic [NCH-1:0]        dvalid_i,
   input  logic [NCH*DW-1:0]     ch_dat_i,
   adc_capture_sequencer_if.master mem,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  irq_o,
   output logic [NCH-1:0]        ovf_o,
   output logic [11:0]           count_o
);

   localparam int D  = NBANK * (2 ** AW);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [11:0] LD = 12'(D);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [NCH-1:0]   r_en;
   logic [11:0]      r_len;
   logic [11:0]      r_cnt;
   logic [NCH-1:0]   r_pend;
   logic [DW-1:0]    r_hold [NCH];
   logic [RW-1:0]    r_rr;
   logic [NBANK-1:0] r_wenb;
   logic [AW-1:0]    r_waddr;
   logic [DW-1:0]    r_data;
   logic             r_busy;
   logic             r_done;
   logic             r_irq;
   logic [NCH-1:0]   r_ovf;

   logic [11:0]      w_npend;
   logic             w_space;
   logic             w_cap;
   logic             w_act;
   logic [NCH-1:0]   w_req;
   logic             w_gv;
   logic [RW-1:0]    w_g;
   logic [RW-1:0]    w_rr_nxt;
   logic [NCH-1:0]   w_gnt;
   logic [NCH-1:0]   w_load;
   logic [NCH-1:0]   w_drop;
   logic             w_wr_idle;
   logic             w_start;
   logic [11:0]      w_len_in;
   logic [BW-1:0]    w_bank;

   assign w_cap     = (r_state == S_CAPTURE);
   assign w_act     = (w_cap || r_state == S_DRAIN) && (r_cnt < r_len);
   assign w_req     = r_pend & r_en & {NCH{w_act}};
   assign w_wr_idle = &r_wenb;
   assign w_bank    = r_cnt[AW+BW-1:AW];
   assign w_start   = start_i && (|ch_en_i)
                    && (r_state == S_IDLE || r_state == S_DONE);
   assign w_len_in  = (length_i == 12'd0 || length_i > LD) ? LD : length_i;
   assign w_rr_nxt  = (w_g == RW'(NCH - 1)) ? '0 : w_g + 1'b1;

   // Occupancy, round-robin pick starting at r_rr, and per-channel load/drop.
   always_comb begin
      int j;
      w_npend = '0;
      w_gv    = 1'b0;
      w_g     = '0;
      j       = 0;
      for (int k = 0; k < NCH; k++)
         w_npend = w_npend + 12'(r_pend[k]);
      w_space = (r_cnt + w_npend) < r_len;
      for (int i = 0; i < NCH; i++) begin
         j = int'(r_rr) + i;
         if (j >= NCH)
            j = j - NCH;
         if (!w_gv && w_req[j]) begin
            w_gv = 1'b1;
            w_g  = RW'(j);
         end
      end
      w_gnt = w_gv ? (NCH'(1) << w_g) : '0;
      for (int k = 0; k < NCH; k++) begin
         w_load[k] = w_cap && r_en[k] && dvalid_i[k] && w_space
                   && (!r_pend[k] || w_gnt[k]);
         w_drop[k] = w_cap && r_en[k] && dvalid_i[k] && w_space
                   && r_pend[k] && !w_gnt[k];
      end
   end

   // Capture FSM with registered SRAM port, status and holding registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_en    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_rr    <= '0;
         r_wenb  <= '1;
         r_waddr <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_irq   <= 1'b0;
         r_ovf   <= '0;
         for (int k = 0; k < NCH; k++)
            r_hold[k] <= '0;
      end else begin
         r_irq  <= 1'b0;
         r_wenb <= '1;
         if (w_gv) begin
            r_wenb  <= ~(NBANK'(1) << w_bank);
            r_waddr <= r_cnt[AW-1:0];
            r_data  <= r_hold[w_g];
            r_cnt   <= r_cnt + 12'd1;
            r_rr    <= w_rr_nxt;
         end
         for (int k = 0; k < NCH; k++)
            if (w_load[k])
               r_hold[k] <= ch_dat_i[k*DW +: DW];
         r_pend <= (r_pend & ~w_gnt) | w_load;
         r_ovf  <= r_ovf | w_drop;
         if (w_start) begin
            r_state <= S_CAPTURE;
            r_en    <= ch_en_i;
            r_len   <= w_len_in;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= '0;
            r_rr    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: ;
               S_CAPTURE: begin
                  if (stop_i) begin
                     r_state <= S_DRAIN;
                  end else if (r_cnt == r_len && w_wr_idle) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_irq   <= 1'b1;
                  end
               end
               S_DRAIN: begin
                  if ((r_pend == '0 || r_cnt == r_len) && w_wr_idle) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_irq   <= 1'b1;
                  end
               end
               S_DONE: ;
            endcase
         end
      end
   end

   assign mem.mem_wenb_o  = r_wenb;
   assign mem.mem_waddr_o = r_waddr;
   assign mem.mem_data_o  = r_data;
   assign mem.wmask_o     = 4'hF;
   assign busy_o          = r_busy;
   assign done_o          = r_done;
   assign irq_o           = r_irq;
   assign ovf_o           = r_ovf;
   assign count_o         = r_cnt;

endmodule
